// File: rtl/fx2_fifo_arbiter.sv
`timescale 1ns / 1ps

// Arbitrates a video byte stream and an atomic audio sample stream onto the
// FX2 slave FIFO write port (EP2 video, EP6 audio, EP4 parked after reset).
//   FX2_IFCLK / MAX2_nRESET     : clock, async active-low reset
//   ENABLE                      : permits new grants
//   VID_REQ/VID_DATA/VID_ACK    : video byte source, ACK consumes at the edge
//   AUD_REQ/AUD_DATA/AUD_ACK    : audio sample source, ACK consumes at the edge
//   FX2_FLAGA / FX2_FLAGB       : EP2 / EP6 not full
//   FX2_FIFOADDR/SLWR/FD_OUT    : registered FIFO select, write strobe, data
//   FX2_PKTEND                  : tied inactive
//   VID_STALL_CNT               : saturating video-blocked-by-full counter
module fx2_fifo_arbiter #(
  parameter int unsigned VID_BURST = 16,
  parameter int unsigned AUD_BURST = 4
) (
  input  logic       FX2_IFCLK,
  input  logic       MAX2_nRESET,
  input  logic       ENABLE,
  input  logic       VID_REQ,
  input  logic [7:0] VID_DATA,
  output logic       VID_ACK,
  input  logic       AUD_REQ,
  input  logic [7:0] AUD_DATA,
  output logic       AUD_ACK,
  input  logic       FX2_FLAGA,
  input  logic       FX2_FLAGB,
  output logic [1:0] FX2_FIFOADDR,
  output logic       FX2_SLWR,
  output logic [7:0] FX2_FD_OUT,
  output logic       FX2_PKTEND,
  output logic [15:0] VID_STALL_CNT
);

  typedef enum logic [1:0] {IDLE, SETUP, AUD_XFER, VID_XFER} state_t;

  localparam logic [1:0] ADDR_EP2 = 2'b00;
  localparam logic [1:0] ADDR_EP4 = 2'b01;
  localparam logic [1:0] ADDR_EP6 = 2'b10;
  localparam logic [7:0] VID_LAST = 8'(VID_BURST - 1);
  localparam logic [3:0] AUD_LAST = 4'(AUD_BURST - 1);

  state_t     state, state_next;
  logic [1:0] addr_next;
  logic [7:0] vid_cnt;
  logic [3:0] aud_cnt;
  logic       wr_en;
  logic [7:0] wr_data;

  assign FX2_PKTEND = 1'b1;
  assign wr_en      = AUD_ACK | VID_ACK;
  assign wr_data    = AUD_ACK ? AUD_DATA : VID_DATA;

  always_comb begin
    state_next = state;
    addr_next  = FX2_FIFOADDR;
    VID_ACK    = 1'b0;
    AUD_ACK    = 1'b0;
    case (state)
      IDLE: begin
        // Audio wins only here; SETUP is skipped when the FIFO is already selected.
        if (ENABLE && AUD_REQ && FX2_FLAGB) begin
          addr_next  = ADDR_EP6;
          state_next = (FX2_FIFOADDR == ADDR_EP6) ? AUD_XFER : SETUP;
        end else if (ENABLE && VID_REQ && FX2_FLAGA) begin
          addr_next  = ADDR_EP2;
          state_next = (FX2_FIFOADDR == ADDR_EP2) ? VID_XFER : SETUP;
        end
      end
      SETUP: begin
        state_next = (FX2_FIFOADDR == ADDR_EP6) ? AUD_XFER : VID_XFER;
      end
      AUD_XFER: begin
        if (AUD_REQ && FX2_FLAGB) begin
          AUD_ACK = 1'b1;
          if (aud_cnt == AUD_LAST) state_next = IDLE;
        end
      end
      VID_XFER: begin
        if (ENABLE && VID_REQ && FX2_FLAGA) begin
          VID_ACK = 1'b1;
          if (vid_cnt == VID_LAST) state_next = IDLE;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge FX2_IFCLK or negedge MAX2_nRESET) begin
    if (!MAX2_nRESET) begin
      state         <= IDLE;
      FX2_FIFOADDR  <= ADDR_EP4;
      FX2_SLWR      <= 1'b1;
      FX2_FD_OUT    <= '0;
      vid_cnt       <= '0;
      aud_cnt       <= '0;
      VID_STALL_CNT <= '0;
    end else begin
      state        <= state_next;
      FX2_FIFOADDR <= addr_next;
      FX2_SLWR     <= ~wr_en;
      if (wr_en) FX2_FD_OUT <= wr_data;

      // Counters only run inside XFER, so clearing outside it covers every entry.
      if (state == IDLE || state == SETUP) begin
        vid_cnt <= '0;
        aud_cnt <= '0;
      end else begin
        if (VID_ACK) vid_cnt <= vid_cnt + 8'd1;
        if (AUD_ACK) aud_cnt <= aud_cnt + 4'd1;
      end

      if (ENABLE && VID_REQ && !FX2_FLAGA && VID_STALL_CNT != '1)
        VID_STALL_CNT <= VID_STALL_CNT + 16'd1;
    end
  end

endmodule

// File: tb/tb_fx2_fifo_arbiter.sv
`timescale 1ns / 1ps

module tb_fx2_fifo_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        vreq;
  logic [7:0]  vdata;
  logic        vack;
  logic        areq;
  logic [7:0]  adata;
  logic        aack;
  logic        fa;
  logic        fb;
  logic [1:0]  addr;
  logic        slwr;
  logic [7:0]  fd;
  logic        pktend;
  logic [15:0] stall;

  int passed = 0;
  int total  = 0;

  logic [7:0] aud_mem [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [1:0] aud_idx = '0;
  logic [7:0] vid_idx = '0;

  always #5 clk = ~clk;

  assign adata = aud_mem[aud_idx];
  assign vdata = vid_idx;

  always @(posedge clk) begin
    if (aack) aud_idx <= aud_idx + 2'd1;
    if (vack) vid_idx <= vid_idx + 8'd1;
  end

  fx2_fifo_arbiter #(.VID_BURST(16), .AUD_BURST(4)) dut (
    .FX2_IFCLK    (clk),
    .MAX2_nRESET  (rst_n),
    .ENABLE       (en),
    .VID_REQ      (vreq),
    .VID_DATA     (vdata),
    .VID_ACK      (vack),
    .AUD_REQ      (areq),
    .AUD_DATA     (adata),
    .AUD_ACK      (aack),
    .FX2_FLAGA    (fa),
    .FX2_FLAGB    (fb),
    .FX2_FIFOADDR (addr),
    .FX2_SLWR     (slwr),
    .FX2_FD_OUT   (fd),
    .FX2_PKTEND   (pktend),
    .VID_STALL_CNT(stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; vreq = 1'b0; areq = 1'b0; fa = 1'b0; fb = 1'b0;
    step(); step();
    chk("rst_addr", 32'(addr), 32'h1);
    chk("rst_slwr", 32'(slwr), 32'h1);
    chk("rst_fd", 32'(fd), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_vack", 32'(vack), 32'h0);
    chk("rst_aack", 32'(aack), 32'h0);
    chk("rst_pktend", 32'(pktend), 32'h1);

    // audio grant from reset: SETUP then 4 writes
    rst_n = 1'b1; en = 1'b1; fa = 1'b1; fb = 1'b1; areq = 1'b1;
    step();
    chk("aud_setup_addr", 32'(addr), 32'h2);
    chk("aud_setup_slwr", 32'(slwr), 32'h1);
    chk("aud_setup_ack", 32'(aack), 32'h0);
    step();
    chk("aud_first_ack", 32'(aack), 32'h1);
    chk("aud_first_slwr", 32'(slwr), 32'h1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("aud_wr_slwr", 32'(slwr), 32'h0);
      chk("aud_wr_fd", 32'(fd), 32'(aud_mem[i]));
    end
    areq = 1'b0;
    step();
    chk("aud_end_slwr", 32'(slwr), 32'h1);
    chk("aud_end_fd", 32'(fd), 32'h44);

    // video burst limit: 16 writes, IDLE, re-grant without SETUP
    vreq = 1'b1;
    step();
    chk("vid_setup_addr", 32'(addr), 32'h0);
    chk("vid_setup_slwr", 32'(slwr), 32'h1);
    step();
    chk("vid_first_ack", 32'(vack), 32'h1);
    for (int i = 0; i < 16; i++) begin
      step();
      chk("vid_wr_slwr", 32'(slwr), 32'h0);
      chk("vid_wr_fd", 32'(fd), 32'(i));
    end
    step();
    chk("vid_gap_slwr", 32'(slwr), 32'h1);
    chk("vid_gap_addr", 32'(addr), 32'h0);
    chk("vid_regrant_ack", 32'(vack), 32'h1);
    step();
    chk("vid_17_slwr", 32'(slwr), 32'h0);
    chk("vid_17_fd", 32'(fd), 32'd16);
    vreq = 1'b0;
    step();
    chk("vid_drop_slwr", 32'(slwr), 32'h1);
    chk("vid_drop_fd", 32'(fd), 32'd16);

    // priority / no preemption: audio requested during byte 3 of video
    vreq = 1'b1;
    step();
    chk("pri_vack", 32'(vack), 32'h1);
    chk("pri_slwr", 32'(slwr), 32'h1);
    for (int i = 0; i < 16; i++) begin
      step();
      chk("pri_vid_slwr", 32'(slwr), 32'h0);
      chk("pri_vid_fd", 32'(fd), 32'(17 + i));
      chk("pri_vid_aack", 32'(aack), 32'h0);
      chk("pri_vid_addr", 32'(addr), 32'h0);
      if (i == 1) areq = 1'b1;
    end
    step();
    chk("pri_setup_addr", 32'(addr), 32'h2);
    chk("pri_setup_slwr", 32'(slwr), 32'h1);
    chk("pri_setup_vack", 32'(vack), 32'h0);
    chk("pri_setup_aack", 32'(aack), 32'h0);
    step();
    chk("pri_aud_ack", 32'(aack), 32'h1);
    chk("pri_aud_vack", 32'(vack), 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("pri_aud_slwr", 32'(slwr), 32'h0);
      chk("pri_aud_fd", 32'(fd), 32'(aud_mem[i]));
    end
    areq = 1'b0; vreq = 1'b0;
    step();
    chk("pri_end_slwr", 32'(slwr), 32'h1);
    chk("pri_end_addr", 32'(addr), 32'h2);

    // audio stall on FLAGB for 5 cycles after byte 2
    areq = 1'b1;
    step();
    chk("stl_direct_ack", 32'(aack), 32'h1);
    chk("stl_direct_slwr", 32'(slwr), 32'h1);
    step();
    chk("stl_b1_fd", 32'(fd), 32'h11);
    step();
    chk("stl_b2_slwr", 32'(slwr), 32'h0);
    chk("stl_b2_fd", 32'(fd), 32'h22);
    fb = 1'b0;
    #1 chk("stl_ack_off", 32'(aack), 32'h0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("stl_hold_slwr", 32'(slwr), 32'h1);
      chk("stl_hold_fd", 32'(fd), 32'h22);
      chk("stl_hold_ack", 32'(aack), 32'h0);
    end
    fb = 1'b1;
    #1 chk("stl_ack_on", 32'(aack), 32'h1);
    step();
    chk("stl_b3_slwr", 32'(slwr), 32'h0);
    chk("stl_b3_fd", 32'(fd), 32'h33);
    step();
    chk("stl_b4_fd", 32'(fd), 32'h44);
    areq = 1'b0;
    step();
    chk("stl_end_slwr", 32'(slwr), 32'h1);
    chk("stl_end_ack", 32'(aack), 32'h0);
    chk("stl_cnt_zero", 32'(stall), 32'h0);

    // video stall counter and saturation
    fa = 1'b0; vreq = 1'b1;
    repeat (10) step();
    chk("cnt_10", 32'(stall), 32'd10);
    en = 1'b0;
    repeat (5) step();
    chk("cnt_frozen", 32'(stall), 32'd10);
    en = 1'b1;
    repeat (65524) step();
    chk("cnt_fffe", 32'(stall), 32'hFFFE);
    step();
    chk("cnt_ffff", 32'(stall), 32'hFFFF);
    repeat (70000 - 65535) step();
    chk("cnt_sat", 32'(stall), 32'hFFFF);
    chk("cnt_no_grant", 32'(vack), 32'h0);
    chk("cnt_slwr", 32'(slwr), 32'h1);

    // reset during video byte 5
    fa = 1'b1;
    step();
    chk("rmb_setup_addr", 32'(addr), 32'h0);
    step();
    chk("rmb_ack", 32'(vack), 32'h1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rmb_wr_slwr", 32'(slwr), 32'h0);
      chk("rmb_wr_fd", 32'(fd), 32'(33 + i));
    end
    rst_n = 1'b0;
    #1;
    chk("rmb_addr", 32'(addr), 32'h1);
    chk("rmb_slwr", 32'(slwr), 32'h1);
    chk("rmb_fd", 32'(fd), 32'h0);
    chk("rmb_vack", 32'(vack), 32'h0);
    chk("rmb_aack", 32'(aack), 32'h0);
    chk("rmb_pktend", 32'(pktend), 32'h1);
    chk("rmb_stall", 32'(stall), 32'h0);
    step();
    rst_n = 1'b1;
    step();
    chk("rmb_re_setup_addr", 32'(addr), 32'h0);
    chk("rmb_re_setup_slwr", 32'(slwr), 32'h1);
    chk("rmb_re_setup_vack", 32'(vack), 32'h0);
    step();
    chk("rmb_re_ack", 32'(vack), 32'h1);
    chk("rmb_re_slwr", 32'(slwr), 32'h1);
    step();
    chk("rmb_re_wr_slwr", 32'(slwr), 32'h0);
    chk("rmb_re_wr_fd", 32'(fd), 32'd38);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fx2_fifo_arbiter.md
FX2_FIFO_ARBITER -- requirements
Module: fx2_fifo_arbiter

Interface
REQ-001 SHALL have parameter VID_BURST, default 16: maximum video bytes per grant (range 1..255).
REQ-002 SHALL have parameter AUD_BURST, default 4: bytes per audio sample grant; the grant is atomic (range 1..15).
REQ-003 SHALL have port FX2_IFCLK  in  1  sole clock; all state on its rising edge.
REQ-004 SHALL have port MAX2_nRESET  in  1  reset; asynchronous, active-low.
REQ-005 SHALL have port ENABLE  in  1  permits new grants when high.
REQ-006 SHALL have port VID_REQ  in  1  at least one video byte is available on VID_DATA.
REQ-007 SHALL have port VID_DATA  in  8  current video byte.
REQ-008 SHALL have port VID_ACK  out  1  combinational; the video byte is consumed at this edge.
REQ-009 SHALL have port AUD_REQ  in  1  a complete AUD_BURST-byte sample is available.
REQ-010 SHALL have port AUD_DATA  in  8  current audio byte.
REQ-011 SHALL have port AUD_ACK  out  1  combinational; the audio byte is consumed at this edge.
REQ-012 SHALL have port FX2_FLAGA  in  1  EP2 (video) not full.
REQ-013 SHALL have port FX2_FLAGB  in  1  EP6 (audio) not full.
REQ-014 SHALL have port FX2_FIFOADDR  out  2  registered; 00=EP2, 10=EP6, 01=EP4 (parked).
REQ-015 SHALL have port FX2_SLWR  out  1  registered; active-low write strobe.
REQ-016 SHALL have port FX2_FD_OUT  out  8  registered write data.
REQ-017 SHALL have port FX2_PKTEND  out  1  constant 1 (packets are never committed early).
REQ-018 SHALL have port VID_STALL_CNT  out  16  saturating count of cycles in which video was blocked by a full FIFO.

Function
REQ-019 SHALL implement the states IDLE, SETUP, AUD_XFER and VID_XFER.
REQ-020 In IDLE: if ENABLE && AUD_REQ && FX2_FLAGB, target = EP6; else if ENABLE && VID_REQ && FX2_FLAGA, target = EP2; otherwise remain in IDLE.
REQ-021 When a target is chosen and it differs from the current FX2_FIFOADDR: load FX2_FIFOADDR and enter SETUP for exactly 1 cycle with SLWR=1, then enter XFER.
REQ-022 When a target equals the current FX2_FIFOADDR, IDLE SHALL enter XFER directly and skip SETUP.
REQ-023 FX2_FIFOADDR SHALL hold its last value through IDLE.
REQ-024 Write timing: in an XFER cycle where (sel REQ && sel FLAG), assert sel ACK; on the next cycle FX2_FD_OUT = sampled byte and FX2_SLWR = 0. Latency is 1 cycle.
REQ-025 In an XFER cycle without a qualifying write, the next cycle SHALL have FX2_SLWR = 1 and FX2_FD_OUT held.
REQ-026 VID_ACK and AUD_ACK SHALL never both be high; neither SHALL be high outside XFER.
REQ-027 AUD_XFER: a 4-bit counter counts acked bytes. A stall on FLAGB=0 or AUD_REQ=0 holds the state. The state exits to IDLE after the AUD_BURST-th ack, regardless of ENABLE.
REQ-028 VID_XFER: an 8-bit counter counts acked bytes. Exit to IDLE occurs at the edge of the VID_BURST-th ack, or at the first cycle with VID_REQ=0, FLAGA=0 or ENABLE=0; no ack is given in that exit cycle.
REQ-029 Audio SHALL have priority only at IDLE decisions; a running video burst is never preempted.
REQ-030 The burst counters SHALL clear on every entry to XFER.
REQ-031 VID_STALL_CNT SHALL increment when ENABLE && VID_REQ && !FX2_FLAGA, and saturate at 0xFFFF.

Reset
REQ-032 With MAX2_nRESET=0, asynchronously: state=IDLE, FX2_FIFOADDR=01, FX2_SLWR=1, FX2_FD_OUT=00, counters=0, VID_STALL_CNT=0.
REQ-033 With MAX2_nRESET=0, both ACKs SHALL be 0 and FX2_PKTEND SHALL be 1.
REQ-034 Reset mid-burst SHALL abandon the burst; no partial-burst state survives.
REQ-035 The first grant after reset SHALL always pass through SETUP, because FX2_FIFOADDR is 01.

Verification
REQ-036 Audio grant: AUD_REQ=1, FLAGB=1, data bytes 11,22,33,44 -> FIFOADDR=10, 1 SETUP cycle, then 4 consecutive SLWR=0 cycles carrying 11,22,33,44, then SLWR=1.
REQ-037 Video burst limit: VID_REQ held 1, FLAGA=1, VID_BURST=16 -> 16 writes, then IDLE, then re-grant without SETUP; the 17th byte appears 2 cycles after the 16th.
REQ-038 Priority/no preemption: AUD_REQ rises during byte 3 of a video burst -> the video burst completes, then FIFOADDR switches to 10 via SETUP and the audio burst follows.
REQ-039 Full stall: FLAGB=0 after audio byte 2 for 5 cycles -> SLWR=1 for 5 cycles, AUD_ACK=0, then bytes 3 and 4 are written; VID_REQ=1 with FLAGA=0 for 70000 cycles -> VID_STALL_CNT=FFFF.
REQ-040 Reset mid-burst: MAX2_nRESET=0 during video byte 5 -> FIFOADDR=01 and SLWR=1 immediately; after release the next grant takes a SETUP cycle.
